// File: rtl/count_bcd_converter.sv
// count_bcd_converter: sequential binary-to-BCD converter (shift-and-add-3,
// one input bit per clock) with a start/busy/done handshake.
// Optional feature: define COUNT_AUTO_START_EN to start a conversion on its own
// after reset release and whenever bin_in differs from the last converted value.
// DIGITS must satisfy 10**DIGITS > 2**WIDTH - 1.

module count_bcd_converter #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e                state;
  logic [WIDTH-1:0]      bin_sh;
  logic [4*DIGITS-1:0]   scratch;
  logic [CntW-1:0]       bit_cnt;

  logic [4*DIGITS-1:0]   scratch_adj;
  logic [4*DIGITS-1:0]   scratch_nxt;
  logic [WIDTH-1:0]      bin_sh_nxt;
  logic                  go;

`ifdef COUNT_AUTO_START_EN
  logic                  fresh;
  logic [WIDTH-1:0]      last_in;

  assign go = start | fresh | (bin_in != last_in);

  // Remember the last started value; fresh requests one conversion after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fresh   <= 1'b1;
      last_in <= '0;
    end else if (state == StIdle && go) begin
      fresh   <= 1'b0;
      last_in <= bin_in;
    end
  end
`else
  assign go = start;
`endif

  // One double-dabble step: add 3 to every digit >= 5, then shift left by one.
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
    {scratch_nxt, bin_sh_nxt} = {scratch_adj, bin_sh} << 1;
  end

  // Control FSM with registered busy/done/bcd_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= StIdle;
      bin_sh  <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (go) begin
            bin_sh  <= bin_in;
            scratch <= '0;
            bit_cnt <= CntW'(WIDTH);
            busy    <= 1'b1;
            state   <= StShift;
          end
        end
        StShift: begin
          scratch <= scratch_nxt;
          bin_sh  <= bin_sh_nxt;
          bit_cnt <= bit_cnt - CntW'(1);
          if (bit_cnt == CntW'(1)) begin
            bcd_out <= scratch_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_bcd_converter.sv
// Self-checking bench for count_bcd_converter: expected BCD values are queued
// when a start is driven and compared when done pulses.

module tb_count_bcd_converter;

  logic       clk;
  logic       rst;
  logic [4:0] bin_in;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] bcd_out;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned done_cnt;
  logic [7:0]  exp_q[$];

  count_bcd_converter #(.WIDTH(5), .DIGITS(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int unsigned n);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(n / 10);
    ones = 4'(n % 10);
    return {tens, ones};
  endfunction

  // Step to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pops one expected value.
  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'(0));
      end else begin
        check("bcd_out", 32'(bcd_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int unsigned d0;
    n_vec    = 0;
    n_err    = 0;
    done_cnt = 0;
    rst      = 1'b0;
    start    = 1'b0;
    bin_in   = 5'd0;

`ifdef COUNT_AUTO_START_EN
    // Counter sweep 18..27 with no explicit start: one conversion after reset
    // and one per value change.
    bin_in = 5'd18;
    repeat (3) step();
    exp_q.push_back(to_bcd(18));
    rst = 1'b1;
    repeat (10) step();
    for (int v = 19; v <= 27; v++) begin
      bin_in = 5'(v);
      exp_q.push_back(to_bcd(v));
      repeat (10) step();
    end
    repeat (20) step();
    check("auto_done_count", 32'(done_cnt), 32'(10));
    check("auto_final_bcd", 32'(bcd_out), 32'h27);
    check("auto_sb_empty", 32'(exp_q.size()), 32'(0));
`else
    // Reset values.
    repeat (2) step();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_bcd", 32'(bcd_out), 32'(0));
    rst = 1'b1;
    step();

    // Counter stimulus without start: nothing may happen.
    for (int v = 18; v <= 27; v++) begin
      bin_in = 5'(v);
      repeat (10) step();
    end
    check("nostart_done_count", 32'(done_cnt), 32'(0));
    check("nostart_bcd", 32'(bcd_out), 32'(0));

    // Single conversion of 27 with cycle-exact handshake.
    bin_in = 5'd27;
    start  = 1'b1;
    exp_q.push_back(to_bcd(27));
    step();
    start = 1'b0;
    check("e0_busy", 32'(busy), 32'(1));
    check("e0_done", 32'(done), 32'(0));
    for (int i = 1; i <= 4; i++) begin
      step();
      check("shift_busy", 32'(busy), 32'(1));
      check("shift_done", 32'(done), 32'(0));
    end
    step();
    check("e5_done", 32'(done), 32'(1));
    check("e5_busy", 32'(busy), 32'(0));
    check("e5_bcd", 32'(bcd_out), 32'h27);
    step();
    check("e6_done", 32'(done), 32'(0));
    check("hold_bcd", 32'(bcd_out), 32'h27);

    // Back-to-back sweep 0..31, each new start taken in the done cycle.
    d0 = done_cnt;
    for (int v = 0; v <= 31; v++) begin
      bin_in = 5'(v);
      start  = 1'b1;
      exp_q.push_back(to_bcd(v));
      step();
      start = 1'b0;
      repeat (5) step();
      check("sweep_done_in_cycle", 32'(done), 32'(1));
    end
    repeat (3) step();
    check("sweep_done_count", 32'(done_cnt - d0), 32'(32));
    check("sweep_last_bcd", 32'(bcd_out), 32'h31);

    // Start during busy is ignored; bin_in change has no effect.
    d0     = done_cnt;
    bin_in = 5'd18;
    start  = 1'b1;
    exp_q.push_back(to_bcd(18));
    step();
    start = 1'b0;
    step();
    bin_in = 5'd5;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    check("ignored_done_count", 32'(done_cnt - d0), 32'(1));
    check("ignored_bcd", 32'(bcd_out), 32'h18);

    // Reset two cycles into a conversion aborts it.
    d0     = done_cnt;
    bin_in = 5'd20;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_bcd", 32'(bcd_out), 32'(0));
    repeat (2) step();
    rst = 1'b1;
    repeat (12) step();
    check("abort_no_done", 32'(done_cnt - d0), 32'(0));
    check("abort_idle_busy", 32'(busy), 32'(0));
    check("sb_empty", 32'(exp_q.size()), 32'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
